instr_sequencer: RTL and testbench

// - Control sequencer for DataPath: drives enable/out-select strobes through fetch (T0-T2) and execute (T3-T6).
// - Replaces per-instruction hand-written benches; decodes IR_VALUE to pick the execute path.
// - Control outputs are a Moore decode of the state register, stable for the whole cycle.
// - Datapath registers capture on the following posedge.

---
 rtl/instr_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_instr_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/execute control sequencer for the DataPath.
// Drives the datapath enable and bus-select strobes through fetch (T0-T2)
// and an opcode-dependent execute path (T3-T6). All control outputs are a
// Moore decode of the state register; the execute states also decode ir.
// Optional build macro: SINGLE_STEP_EN parks the sequencer in STEP_WAIT
// after every instruction until step=1. Without it the sequencer runs freely.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for start after reset/clear
// T0        | PC onto bus, load MAR, increment PC into Z
// T1        | Z back to PC, memory read into MDR (held MEM_WAIT+1 cycles)
// T2        | MDR into IR
// T3..T6    | execute, path chosen by the opcode class of ir
// HALTED    | after HALT; only clear leaves
// STEP_WAIT | single-step park after an instruction (SINGLE_STEP_EN only)

module instr_sequencer #(
    parameter int MEM_WAIT = 0,
    parameter int NREG     = 16
) (
    input  logic            clock,
    input  logic            clear,
    input  logic [31:0]     ir,
    input  logic            start,
    input  logic            step,
    output logic            PCout,
    output logic            IncPC,
    output logic            MARin,
    output logic            Zin,
    output logic            Zlo_out,
    output logic            Zhi_out,
    output logic            PCin,
    output logic            Read,
    output logic            MDRin,
    output logic            MDRout,
    output logic            IRin,
    output logic            Yin,
    output logic            HIin,
    output logic            LOin,
    output logic [NREG-1:0] Rin,
    output logic [NREG-1:0] Rout,
    output logic [4:0]      opcode,
    output logic            running,
    output logic            instr_done
);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALTED, S_STEP_WAIT
    } state_t;

    typedef enum logic [2:0] {
        C_BINARY, C_MULDIV, C_UNARY, C_HALT, C_NOP
    } op_class_t;

`ifdef SINGLE_STEP_EN
    localparam state_t S_AFTER_DONE = S_STEP_WAIT;
`else
    localparam state_t S_AFTER_DONE = S_T0;
`endif

    localparam int WCW = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;

    state_t          state;
    state_t          state_next;
    op_class_t       op_class;
    logic [WCW-1:0]  wait_cnt;
    logic [4:0]      op;
    logic [NREG-1:0] ra_oh;
    logic [NREG-1:0] rb_oh;
    logic [NREG-1:0] rc_oh;
    logic            unused_ir;

    assign op        = ir[31:27];
    assign unused_ir = ^ir[14:0];

    // Register-field to one-hot bus select; fields past NREG select nothing.
    function automatic logic [NREG-1:0] field_onehot(input logic [3:0] f);
        logic [NREG-1:0] v;
        v = '0;
        for (int i = 0; i < NREG; i++) begin
            if ({28'd0, f} == i) v[i] = 1'b1;
        end
        return v;
    endfunction

    assign ra_oh = field_onehot(ir[26:23]);
    assign rb_oh = field_onehot(ir[22:19]);
    assign rc_oh = field_onehot(ir[18:15]);

    // Opcode class decode picks the execute path.
    always_comb begin
        op_class = C_NOP;
        if (op <= 5'd14)                     op_class = C_BINARY;
        else if (op == 5'd15 || op == 5'd16) op_class = C_MULDIV;
        else if (op == 5'd17 || op == 5'd18) op_class = C_UNARY;
        else if (op == 5'd27)                op_class = C_HALT;
    end

    // State register.
    always_ff @(posedge clock) begin
        if (clear) state <= S_IDLE;
        else       state <= state_next;
    end

    // Memory wait down-counter: loaded in T0 so it is fresh on every T1 entry.
    always_ff @(posedge clock) begin
        if (clear)
            wait_cnt <= '0;
        else if (state == S_T0)
            wait_cnt <= WCW'(MEM_WAIT);
        else if (state == S_T1 && wait_cnt != '0)
            wait_cnt <= wait_cnt - WCW'(1);
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:      if (start) state_next = S_T0;
            S_T0:        state_next = S_T1;
            S_T1:        if (wait_cnt == '0) state_next = S_T2;
            S_T2:        state_next = S_T3;
            S_T3: begin
                case (op_class)
                    C_BINARY, C_MULDIV, C_UNARY: state_next = S_T4;
                    C_HALT:                      state_next = S_HALTED;
                    default:                     state_next = S_AFTER_DONE;
                endcase
            end
            S_T4:        state_next = (op_class == C_UNARY)  ? S_AFTER_DONE : S_T5;
            S_T5:        state_next = (op_class == C_MULDIV) ? S_T6 : S_AFTER_DONE;
            S_T6:        state_next = S_AFTER_DONE;
            S_HALTED:    state_next = S_HALTED;
            S_STEP_WAIT: if (step) state_next = S_T0;
            default:     state_next = S_IDLE;
        endcase
    end

    // Moore output decode; everything defaults low.
    always_comb begin
        PCout = 1'b0; IncPC = 1'b0; MARin = 1'b0; Zin = 1'b0;
        Zlo_out = 1'b0; Zhi_out = 1'b0; PCin = 1'b0; Read = 1'b0;
        MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0; Yin = 1'b0;
        HIin = 1'b0; LOin = 1'b0;
        Rin = '0; Rout = '0; opcode = 5'd0;
        running = 1'b0; instr_done = 1'b0;
        case (state)
            S_T0: begin
                running = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
            end
            S_T1: begin
                running = 1'b1; Zlo_out = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
            end
            S_T2: begin
                running = 1'b1; MDRout = 1'b1; IRin = 1'b1;
            end
            S_T3: begin
                running = 1'b1;
                case (op_class)
                    C_BINARY, C_MULDIV: begin
                        Rout = rb_oh; Yin = 1'b1;
                    end
                    C_UNARY: begin
                        Rout = rb_oh; opcode = op; Zin = 1'b1;
                    end
                    default: instr_done = 1'b1;
                endcase
            end
            S_T4: begin
                running = 1'b1;
                if (op_class == C_UNARY) begin
                    Zlo_out = 1'b1; Rin = ra_oh; instr_done = 1'b1;
                end else begin
                    Rout = rc_oh; opcode = op; Zin = 1'b1;
                end
            end
            S_T5: begin
                running = 1'b1; Zlo_out = 1'b1;
                if (op_class == C_MULDIV) begin
                    LOin = 1'b1;
                end else begin
                    Rin = ra_oh; instr_done = 1'b1;
                end
            end
            S_T6: begin
                running = 1'b1; Zhi_out = 1'b1; HIin = 1'b1; instr_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_instr_sequencer.sv
`timescale 1ns/1ps
module tb_instr_sequencer;

    localparam int NREG_A = 16;
    localparam int NREG_B = 8;
    localparam int MW_A   = 0;
    localparam int MW_B   = 2;

    localparam logic [13:0] PCOUT  = 14'h2000;
    localparam logic [13:0] INCPC  = 14'h1000;
    localparam logic [13:0] MARIN  = 14'h0800;
    localparam logic [13:0] ZIN    = 14'h0400;
    localparam logic [13:0] ZLO    = 14'h0200;
    localparam logic [13:0] ZHI    = 14'h0100;
    localparam logic [13:0] PCIN   = 14'h0080;
    localparam logic [13:0] READ   = 14'h0040;
    localparam logic [13:0] MDRIN  = 14'h0020;
    localparam logic [13:0] MDROUT = 14'h0010;
    localparam logic [13:0] IRIN   = 14'h0008;
    localparam logic [13:0] YIN    = 14'h0004;
    localparam logic [13:0] HIIN   = 14'h0002;
    localparam logic [13:0] LOIN   = 14'h0001;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        clear_a, start_a, step_a;
    logic [31:0] ir_a;
    logic        PCout_a, IncPC_a, MARin_a, Zin_a, Zlo_out_a, Zhi_out_a, PCin_a;
    logic        Read_a, MDRin_a, MDRout_a, IRin_a, Yin_a, HIin_a, LOin_a;
    logic [NREG_A-1:0] Rin_a, Rout_a;
    logic [4:0]  opcode_a;
    logic        running_a, instr_done_a;

    logic        clear_b, start_b, step_b;
    logic [31:0] ir_b;
    logic        PCout_b, IncPC_b, MARin_b, Zin_b, Zlo_out_b, Zhi_out_b, PCin_b;
    logic        Read_b, MDRin_b, MDRout_b, IRin_b, Yin_b, HIin_b, LOin_b;
    logic [NREG_B-1:0] Rin_b, Rout_b;
    logic [4:0]  opcode_b;
    logic        running_b, instr_done_b;

    instr_sequencer #(.MEM_WAIT(MW_A), .NREG(NREG_A)) dut_a (
        .clock(clock), .clear(clear_a), .ir(ir_a), .start(start_a), .step(step_a),
        .PCout(PCout_a), .IncPC(IncPC_a), .MARin(MARin_a), .Zin(Zin_a),
        .Zlo_out(Zlo_out_a), .Zhi_out(Zhi_out_a), .PCin(PCin_a), .Read(Read_a),
        .MDRin(MDRin_a), .MDRout(MDRout_a), .IRin(IRin_a), .Yin(Yin_a),
        .HIin(HIin_a), .LOin(LOin_a), .Rin(Rin_a), .Rout(Rout_a),
        .opcode(opcode_a), .running(running_a), .instr_done(instr_done_a)
    );

    instr_sequencer #(.MEM_WAIT(MW_B), .NREG(NREG_B)) dut_b (
        .clock(clock), .clear(clear_b), .ir(ir_b), .start(start_b), .step(step_b),
        .PCout(PCout_b), .IncPC(IncPC_b), .MARin(MARin_b), .Zin(Zin_b),
        .Zlo_out(Zlo_out_b), .Zhi_out(Zhi_out_b), .PCin(PCin_b), .Read(Read_b),
        .MDRin(MDRin_b), .MDRout(MDRout_b), .IRin(IRin_b), .Yin(Yin_b),
        .HIin(HIin_b), .LOin(LOin_b), .Rin(Rin_b), .Rout(Rout_b),
        .opcode(opcode_b), .running(running_b), .instr_done(instr_done_b)
    );

    logic [52:0] obs_a, obs_b;
    assign obs_a = {PCout_a, IncPC_a, MARin_a, Zin_a, Zlo_out_a, Zhi_out_a, PCin_a,
                    Read_a, MDRin_a, MDRout_a, IRin_a, Yin_a, HIin_a, LOin_a,
                    Rin_a, Rout_a, opcode_a, running_a, instr_done_a};
    assign obs_b = {PCout_b, IncPC_b, MARin_b, Zin_b, Zlo_out_b, Zhi_out_b, PCin_b,
                    Read_b, MDRin_b, MDRout_b, IRin_b, Yin_b, HIin_b, LOin_b,
                    8'd0, Rin_b, 8'd0, Rout_b, opcode_b, running_b, instr_done_b};

    int checks = 0;
    int errors = 0;
    logic [52:0] exp_q[$];

    function automatic logic [52:0] mk(input logic [13:0] s, input logic [15:0] rin,
                                       input logic [15:0] rout, input logic [4:0] opc,
                                       input logic run, input logic done);
        return {s, rin, rout, opc, run, done};
    endfunction

    function automatic logic [15:0] oh(input logic [3:0] f, input int n);
        if (f < n) return 16'd1 << f;
        return 16'd0;
    endfunction

    // Reference model: per-instruction list of expected per-cycle strobe words.
    task automatic gen_instr(input bit d, input logic [31:0] instr, input bit last);
        int mw, nreg;
        logic [4:0] op;
        logic [15:0] ra, rb, rc;
        bit halt;
        mw   = d ? MW_B : MW_A;
        nreg = d ? NREG_B : NREG_A;
        op   = instr[31:27];
        ra   = oh(instr[26:23], nreg);
        rb   = oh(instr[22:19], nreg);
        rc   = oh(instr[18:15], nreg);
        halt = 1'b0;
        exp_q.push_back(mk(PCOUT | MARIN | INCPC | ZIN, 16'd0, 16'd0, 5'd0, 1'b1, 1'b0));
        for (int i = 0; i <= mw; i++)
            exp_q.push_back(mk(ZLO | PCIN | READ | MDRIN, 16'd0, 16'd0, 5'd0, 1'b1, 1'b0));
        exp_q.push_back(mk(MDROUT | IRIN, 16'd0, 16'd0, 5'd0, 1'b1, 1'b0));
        if (op <= 5'd14) begin
            exp_q.push_back(mk(YIN, 16'd0, rb, 5'd0, 1'b1, 1'b0));
            exp_q.push_back(mk(ZIN, 16'd0, rc, op, 1'b1, 1'b0));
            exp_q.push_back(mk(ZLO, ra, 16'd0, 5'd0, 1'b1, 1'b1));
        end else if (op == 5'd15 || op == 5'd16) begin
            exp_q.push_back(mk(YIN, 16'd0, rb, 5'd0, 1'b1, 1'b0));
            exp_q.push_back(mk(ZIN, 16'd0, rc, op, 1'b1, 1'b0));
            exp_q.push_back(mk(ZLO | LOIN, 16'd0, 16'd0, 5'd0, 1'b1, 1'b0));
            exp_q.push_back(mk(ZHI | HIIN, 16'd0, 16'd0, 5'd0, 1'b1, 1'b1));
        end else if (op == 5'd17 || op == 5'd18) begin
            exp_q.push_back(mk(ZIN, 16'd0, rb, op, 1'b1, 1'b0));
            exp_q.push_back(mk(ZLO, ra, 16'd0, 5'd0, 1'b1, 1'b1));
        end else if (op == 5'd27) begin
            exp_q.push_back(mk(14'd0, 16'd0, 16'd0, 5'd0, 1'b1, 1'b1));
            halt = 1'b1;
        end else begin
            exp_q.push_back(mk(14'd0, 16'd0, 16'd0, 5'd0, 1'b1, 1'b1));
        end
        if (halt) begin
            repeat (3) exp_q.push_back(53'd0);
        end else if (last) begin
`ifdef SINGLE_STEP_EN
            exp_q.push_back(53'd0);
`else
            exp_q.push_back(mk(PCOUT | MARIN | INCPC | ZIN, 16'd0, 16'd0, 5'd0, 1'b1, 1'b0));
`endif
        end else begin
`ifdef SINGLE_STEP_EN
            exp_q.push_back(53'd0);
`endif
        end
    endtask

    task automatic drive_start(input bit d, input logic v);
        if (d) start_b = v; else start_a = v;
    endtask

    task automatic drive_clear(input bit d, input logic v);
        if (d) clear_b = v; else clear_a = v;
    endtask

    task automatic drive_step(input bit d, input logic v);
        if (d) step_b = v; else step_a = v;
    endtask

    task automatic set_ir(input bit d, input logic [31:0] v);
        if (d) ir_b = v; else ir_a = v;
    endtask

    task automatic apply_clear(input bit d, input string name);
        logic [52:0] o;
        drive_clear(d, 1'b1);
        @(posedge clock); #1;
        drive_clear(d, 1'b0);
        drive_start(d, 1'b0);
        @(negedge clock);
        o = d ? obs_b : obs_a;
        checks++;
        if (o !== 53'd0) begin
            errors++;
            $display("FAIL %s dut%0d: outputs got %h expected 0", name, d, o);
        end
        @(posedge clock); #1;
    endtask

    task automatic compare_q(input bit d, input string name, input int n, input bit rnd);
        logic [52:0] e, o;
        int cyc;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < n) begin
            @(negedge clock);
            e = exp_q.pop_front();
            o = d ? obs_b : obs_a;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, d, cyc, o, e);
            end
            cyc++;
            if (cyc < n && exp_q.size() > 0) begin
                @(posedge clock); #1;
                if (rnd) drive_start(d, 1'($urandom_range(0, 1)));
            end
        end
        if (rnd) drive_start(d, 1'b0);
    endtask

    task automatic go(input bit d, input string name, input int n, input bit rnd);
        drive_start(d, 1'b1);
        @(posedge clock); #1;
        drive_start(d, 1'b0);
        compare_q(d, name, n, rnd);
    endtask

    task automatic run_one(input bit d, input logic [31:0] instr, input string name);
        exp_q.delete();
        gen_instr(d, instr, 1'b1);
        apply_clear(d, {name, "_clear"});
        set_ir(d, instr);
        go(d, name, 1000, 1'b1);
    endtask

    task automatic test_reset();
        apply_clear(1'b0, "reset");
        apply_clear(1'b1, "reset");
    endtask

    task automatic test_binary();
        run_one(1'b0, 32'h28918000, "binary");
    endtask

    task automatic test_unary();
        run_one(1'b0, 32'h8B380000, "unary_neg");
    endtask

    task automatic test_muldiv();
        run_one(1'b0, 32'h78118000, "mul");
        run_one(1'b0, {5'd16, 4'd5, 4'd14, 4'd0, 15'd0}, "div");
    endtask

    task automatic test_mem_wait();
        run_one(1'b1, 32'h28918000, "mem_wait");
        run_one(1'b1, {5'd1, 4'd9, 4'd12, 4'd15, 15'd0}, "field_over_nreg");
        run_one(1'b1, {5'd18, 4'd8, 4'd7, 4'd0, 15'd0}, "not_partial_field");
    endtask

    task automatic test_halt();
        run_one(1'b0, 32'hD8000000, "halt");
        exp_q.delete();
        gen_instr(1'b0, 32'hF8000000, 1'b1);
        apply_clear(1'b0, "halt_exit_clear");
        set_ir(1'b0, 32'hF8000000);
        go(1'b0, "halt_resume_nop", 1000, 1'b1);
    endtask

    task automatic test_clear_mid();
        logic [52:0] o;
        exp_q.delete();
        gen_instr(1'b0, 32'h28918000, 1'b1);
        apply_clear(1'b0, "clear_mid_pre");
        set_ir(1'b0, 32'h28918000);
        go(1'b0, "clear_mid_fetch", 4, 1'b0);
        @(posedge clock); #1;
        clear_a = 1'b1;
        compare_q(1'b0, "clear_mid_t4", 1, 1'b0);
        @(posedge clock); #1;
        clear_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i >= 2) step_a = 1'b1;
            @(negedge clock);
            o = obs_a;
            checks++;
            if (o !== 53'd0) begin
                errors++;
                $display("FAIL clear_mid_idle cycle %0d: got %h expected 0", i, o);
            end
            @(posedge clock); #1;
        end
        step_a = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n1, n2;
        logic [31:0] i1, i2, i3;
        i1 = 32'h78118000;
        i2 = 32'h8B380000;
        i3 = {5'd3, 4'd15, 4'd0, 4'd4, 15'd0};
        exp_q.delete();
        gen_instr(1'b0, i1, 1'b0);
        n1 = exp_q.size();
        gen_instr(1'b0, i2, 1'b0);
        n2 = exp_q.size() - n1;
        gen_instr(1'b0, i3, 1'b1);
        apply_clear(1'b0, "b2b_clear");
        step_a = 1'b1;
        set_ir(1'b0, i1);
        go(1'b0, "b2b_1", n1, 1'b1);
        @(posedge clock); #1;
        set_ir(1'b0, i2);
        compare_q(1'b0, "b2b_2", n2, 1'b1);
        @(posedge clock); #1;
        set_ir(1'b0, i3);
        compare_q(1'b0, "b2b_3", 1000, 1'b1);
        step_a = 1'b0;
    endtask

    task automatic test_random();
        bit d;
        logic [31:0] instr;
        for (int k = 0; k < 24; k++) begin
            d = 1'($urandom_range(0, 1));
            instr = $urandom;
            run_one(d, instr, "random");
        end
    endtask

    initial begin
        clear_a = 1'b1; start_a = 1'b0; step_a = 1'b0; ir_a = 32'd0;
        clear_b = 1'b1; start_b = 1'b0; step_b = 1'b0; ir_b = 32'd0;
        @(posedge clock); #1;
        test_reset();
        test_binary();
        test_unary();
        test_muldiv();
        test_mem_wait();
        test_halt();
        test_clear_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
